reset_release_sequencer: RTL and testbench

Produces the reset inputs for a group of asynchronously-reset register domains. It asserts all outputs together and holds them for a programmed number of cycles. It then deasserts them one domain at a time, in index order, on clean clock-edge boundaries, so consumers always see a synchronized reset deassertion. It sits at the reset-distribution point of a subsystem and also accepts software/debug reset requests at runtime.

---
 rtl/reset_release_sequencer.sv | 120 ++++++++++++
 tb/tb_reset_release_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts all domain resets together, holds them for
// HOLD_CYCLES enabled edges, then releases one domain every STAGGER_CYCLES.
module reset_release_sequencer #(
   parameter int N_DOMAINS      = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 en,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 busy,
   output logic                 done
);

   localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

   // Terminal counts must be representable, otherwise the counter would wrap.
   if (N_DOMAINS < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_params
      $error("reset_release_sequencer: N_DOMAINS, HOLD_CYCLES, STAGGER_CYCLES must be >= 1");
   end
   if (CNT_W < 31 && (2 ** CNT_W) <= MAX_CYC) begin : g_bad_cnt_w
      $error("reset_release_sequencer: CNT_W too small for HOLD_CYCLES/STAGGER_CYCLES");
   end

   typedef enum logic [1:0] {
      S_HOLD,
      S_RELEASE,
      S_IDLE
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      busy_d    = busy_q;
      done_d    = done_q;
      if (req) begin
         // Runtime request restarts from scratch, re-asserting released domains.
         state_d   = S_HOLD;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '1;
         busy_d    = 1'b1;
         done_d    = 1'b0;
      end else if (en) begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_out_d[0] = 1'b0;
                  cnt_d        = '0;
                  if (N_DOMAINS == 1) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = IDX_W'(1);
                     state_d = S_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RELEASE: begin
               if (cnt_q == STAG_LAST) begin
                  rst_out_d[idx_q] = 1'b0;
                  cnt_d            = '0;
                  idx_d            = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_HOLD;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rst_out = rst_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: timing-formula model feeding a scoreboard,
// a segment table for the cold-reset and en-stall sequences, and hand corners.
module tb_reset_release_sequencer;

   localparam int N = 4;
   localparam int H = 16;
   localparam int S = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, req, en;
   logic [N-1:0] rst_out;
   logic         busy, done;

   logic         rst_b, req_b, en_b;
   logic [0:0]   rst_out_b;
   logic         busy_b, done_b;

   int checks = 0;
   int errors = 0;
   int t      = 0;   // enabled edges since the last rst/req edge

   reset_release_sequencer #(.N_DOMAINS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .req(req), .en(en),
      .rst_out(rst_out), .busy(busy), .done(done)
   );

   reset_release_sequencer #(.N_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst_b), .req(req_b), .en(en_b),
      .rst_out(rst_out_b), .busy(busy_b), .done(done_b)
   );

   typedef struct {
      logic [N-1:0] ro;
      logic         busy;
      logic         done;
      string        name;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      int           ncyc;
      logic         rst, req, en;
      logic [N-1:0] ro;
      logic         busy;
      logic         done;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Domain i is in reset until HOLD + i*STAGGER enabled edges have elapsed.
   function automatic exp_t model(input int tt, input string name);
      exp_t e;
      for (int i = 0; i < N; i++) e.ro[i] = (tt < H + i * S);
      e.busy = |e.ro;
      e.done = ~e.busy;
      e.name = name;
      return e;
   endfunction

   task automatic step(input logic r, input logic q, input logic e, input string name);
      exp_t x;
      rst = r; req = q; en = e;
      if (r || q)      t = 0;
      else if (e && t < 1000) t++;
      sbq.push_back(model(t, name));
      @(posedge clk);
      #1;
      x = sbq.pop_front();
      chk({x.name, "_rst_out"}, 32'(rst_out), 32'(x.ro));
      chk({x.name, "_busy_done"}, {30'd0, busy, done}, {30'd0, x.busy, x.done});
   endtask

   task automatic run(input int n, input logic r, input logic q, input logic e, input string name);
      for (int i = 0; i < n; i++) step(r, q, e, name);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; en = 1'b1;
      rst_b = 1'b1; req_b = 1'b0; en_b = 1'b1;

      // Segments: cold reset sequence, then a 5-edge en stall starting at edge 10.
      vecs[0]  = '{3,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[1]  = '{15, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[2]  = '{1,  1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0};
      vecs[3]  = '{7,  1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0};
      vecs[4]  = '{1,  1'b0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0};
      vecs[5]  = '{8,  1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
      vecs[6]  = '{7,  1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
      vecs[7]  = '{1,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
      vecs[8]  = '{5,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
      vecs[9]  = '{1,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[10] = '{9,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[11] = '{5,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0};
      vecs[12] = '{6,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[13] = '{1,  1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0};
      vecs[14] = '{7,  1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0};
      vecs[15] = '{1,  1'b0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0};
      vecs[16] = '{8,  1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
      vecs[17] = '{7,  1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
      vecs[18] = '{1,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
      vecs[19] = '{3,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};

      for (int v = 0; v < 20; v++) begin
         run(vecs[v].ncyc, vecs[v].rst, vecs[v].req, vecs[v].en, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_table_rst_out", v), 32'(rst_out), 32'(vecs[v].ro));
         chk($sformatf("vec%0d_table_flags", v), {30'd0, busy, done},
             {30'd0, vecs[v].busy, vecs[v].done});
      end

      // req pulse while idle: restart with full spacing from the req-low edge.
      step(1'b0, 1'b1, 1'b1, "req_idle");
      chk("req_idle_restart", {26'd0, rst_out, busy, done}, {26'd0, 4'b1111, 1'b1, 1'b0});
      run(15, 1'b0, 1'b0, 1'b1, "req_idle_hold");
      chk("req_idle_e15", 32'(rst_out), 32'h0f);
      step(1'b0, 1'b0, 1'b1, "req_idle_e16");
      chk("req_idle_e16_rel0", 32'(rst_out), 32'h0e);
      run(24, 1'b0, 1'b0, 1'b1, "req_idle_tail");
      chk("req_idle_e40_done", {26'd0, rst_out, busy, done}, {26'd0, 4'b0000, 1'b0, 1'b1});

      // req at edge 26 (after domain 1 released) re-asserts everything.
      step(1'b1, 1'b0, 1'b1, "rst_pre_req26");
      run(25, 1'b0, 1'b0, 1'b1, "pre_req26");
      chk("pre_req26_state", 32'(rst_out), 32'h0c);
      step(1'b0, 1'b1, 1'b1, "req26");
      chk("req26_reassert", {26'd0, rst_out, busy, done}, {26'd0, 4'b1111, 1'b1, 1'b0});
      run(15, 1'b0, 1'b0, 1'b1, "post_req26");
      chk("post_req26_no_early_release", 32'(rst_out), 32'h0f);
      step(1'b0, 1'b0, 1'b1, "post_req26_e16");
      chk("post_req26_e16", 32'(rst_out), 32'h0e);

      // rst and req together mid-RELEASE, then a cold-reset-identical sequence.
      run(14, 1'b0, 1'b0, 1'b1, "to_e30");
      step(1'b1, 1'b1, 1'b1, "rst_req");
      chk("rst_req_reassert", {26'd0, rst_out, busy, done}, {26'd0, 4'b1111, 1'b1, 1'b0});
      run(40, 1'b0, 1'b0, 1'b1, "after_rst_req");
      chk("after_rst_req_done", {26'd0, rst_out, busy, done}, {26'd0, 4'b0000, 1'b0, 1'b1});

      // Random req/en traffic against the model.
      for (int i = 0; i < 400; i++)
         step(1'b0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), "rand");

      // Single-domain, 1-cycle configuration.
      @(posedge clk); #1;
      chk("b_reset", {29'd0, rst_out_b, busy_b, done_b}, {29'd0, 1'b1, 1'b1, 1'b0});
      rst_b = 1'b0;
      @(posedge clk); #1;
      chk("b_first_edge", {29'd0, rst_out_b, busy_b, done_b}, {29'd0, 1'b0, 1'b0, 1'b1});
      req_b = 1'b1;
      @(posedge clk); #1;
      chk("b_req", {29'd0, rst_out_b, busy_b, done_b}, {29'd0, 1'b1, 1'b1, 1'b0});
      req_b = 1'b0; en_b = 1'b0;
      @(posedge clk); #1;
      chk("b_en_stall", {29'd0, rst_out_b, busy_b, done_b}, {29'd0, 1'b1, 1'b1, 1'b0});
      en_b = 1'b1;
      @(posedge clk); #1;
      chk("b_release", {29'd0, rst_out_b, busy_b, done_b}, {29'd0, 1'b0, 1'b0, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
